// File: rtl/ksl_add_engine_if.sv
// Request, result, cache-read and clear signals of the KSL attenuation engine.
// The master drives requests and consumes results; the slave is the engine.
interface ksl_add_engine_if #(
  parameter int CHAN_WIDTH    = 4,
  parameter int KSL_ADD_WIDTH = 8
) ();
  localparam int REG_FNUM_WIDTH  = 10;
  localparam int REG_BLOCK_WIDTH = 3;
  localparam int REG_KSL_WIDTH   = 2;

  logic                       in_valid;
  logic                       in_ready;
  logic [CHAN_WIDTH-1:0]      in_chan;
  logic [REG_FNUM_WIDTH-1:0]  fnum;
  logic [REG_BLOCK_WIDTH-1:0] block;
  logic [REG_KSL_WIDTH-1:0]   ksl;
  logic                       out_valid;
  logic                       out_ready;
  logic [CHAN_WIDTH-1:0]      out_chan;
  logic [KSL_ADD_WIDTH-1:0]   out_ksl_add;
  logic                       clear;
  logic                       busy;
  logic [CHAN_WIDTH-1:0]      rd_chan;
  logic [KSL_ADD_WIDTH-1:0]   rd_ksl_add;

  modport master (
    output in_valid, in_chan, fnum, block, ksl, out_ready, clear, rd_chan,
    input  in_ready, out_valid, out_chan, out_ksl_add, busy, rd_ksl_add
  );

  modport slave (
    input  in_valid, in_chan, fnum, block, ksl, out_ready, clear, rd_chan,
    output in_ready, out_valid, out_chan, out_ksl_add, busy, rd_ksl_add
  );
endinterface

// File: rtl/ksl_add_engine.sv
// Two-stage KSL attenuation pipeline with stall-on-backpressure.
// Define KSL_ADD_CACHE_EN to build the per-channel result cache, read port and clear FSM.
module ksl_add_engine #(
  parameter int NUM_CHANNELS  = 9,
  parameter int CHAN_WIDTH    = 4,
  parameter int KSL_ADD_WIDTH = 8
) (
  input logic clk,
  input logic rst,
  ksl_add_engine_if.slave bus
);

  localparam logic [6:0] KSL_ROM [16] = '{
    7'd0,  7'd32, 7'd40, 7'd45, 7'd48, 7'd51, 7'd53, 7'd55,
    7'd56, 7'd58, 7'd59, 7'd60, 7'd61, 7'd62, 7'd63, 7'd64
  };

  logic                     s1_valid;
  logic [6:0]               s1_rom;
  logic [2:0]               s1_block;
  logic [1:0]               s1_ksl;
  logic [CHAN_WIDTH-1:0]    s1_chan;
  logic                     s2_valid;
  logic [CHAN_WIDTH-1:0]    s2_chan;
  logic [KSL_ADD_WIDTH-1:0] s2_ksl_add;
  logic                     s2_advance;
  logic                     pipe_ready;
  logic                     in_fire;
  logic signed [8:0]        t;
  logic [7:0]               t_mag;
  logic [7:0]               s2_result;
  logic                     unused_fnum_lsbs;

  assign s2_advance       = !s2_valid || bus.out_ready;
  assign pipe_ready       = !s1_valid || s2_advance;
  assign in_fire          = bus.in_valid && bus.in_ready;
  assign unused_fnum_lsbs = ^bus.fnum[5:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_rom   <= '0;
      s1_block <= '0;
      s1_ksl   <= '0;
      s1_chan  <= '0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
      s1_rom   <= KSL_ROM[bus.fnum[9:6]];
      s1_block <= bus.block;
      s1_ksl   <= bus.ksl;
      s1_chan  <= bus.in_chan;
    end else if (s2_advance) begin
      s1_valid <= 1'b0;
    end
  end

  // t = rom + 8*(block-8); the positive range tops out at 56, so 8 bits hold t<<2
  assign t     = $signed({2'b00, s1_rom}) + $signed({3'b000, s1_block, 3'b000}) - 9'sd64;
  assign t_mag = t[7:0];

  always_comb begin
    s2_result = '0;
    if (!t[8] && (t != 9'sd0)) begin
      case (s1_ksl)
        2'd1:    s2_result = t_mag << 1;
        2'd2:    s2_result = t_mag;
        2'd3:    s2_result = t_mag << 2;
        default: s2_result = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_valid   <= 1'b0;
      s2_chan    <= '0;
      s2_ksl_add <= '0;
    end else if (s2_advance) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_chan    <= s1_chan;
        s2_ksl_add <= KSL_ADD_WIDTH'(s2_result);
      end
    end
  end

  assign bus.out_valid   = s2_valid;
  assign bus.out_chan    = s2_chan;
  assign bus.out_ksl_add = s2_ksl_add;

`ifdef KSL_ADD_CACHE_EN
  localparam logic [CHAN_WIDTH-1:0] LAST_CHAN = CHAN_WIDTH'(NUM_CHANNELS - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                   state_q;
  state_t                   state_d;
  logic [CHAN_WIDTH-1:0]    cnt_q;
  logic [KSL_ADD_WIDTH-1:0] cache [NUM_CHANNELS];
  logic [KSL_ADD_WIDTH-1:0] rd_q;
  logic                     wr_en;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= (state_q == CLEAR) ? cnt_q + 1'b1 : '0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.clear) state_d = CLEAR;
      CLEAR:   if (cnt_q == LAST_CHAN) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Results draining while the clear runs still leave on out_* but never land in the cache
  assign wr_en = bus.out_valid && bus.out_ready && (bus.out_chan <= LAST_CHAN) && (state_q == IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CHANNELS; i++) cache[i] <= '0;
      rd_q <= '0;
    end else begin
      if (state_q == CLEAR) cache[cnt_q] <= '0;
      else if (wr_en) cache[bus.out_chan] <= bus.out_ksl_add;
      rd_q <= (bus.rd_chan <= LAST_CHAN) ? cache[bus.rd_chan] : '0;
    end
  end

  assign bus.in_ready   = (state_q == IDLE) && pipe_ready;
  assign bus.busy       = (state_q == CLEAR);
  assign bus.rd_ksl_add = rd_q;
`else
  logic unused_cache_inputs;

  assign unused_cache_inputs = ^{bus.clear, bus.rd_chan};
  assign bus.in_ready        = pipe_ready;
  assign bus.busy            = 1'b0;
  assign bus.rd_ksl_add      = '0;
`endif

endmodule

// File: tb/tb_ksl_add_engine.sv
// Self-checking bench for ksl_add_engine: directed steps plus random traffic against a
// queue/array reference model; cache expectations follow KSL_ADD_CACHE_EN.
module tb_ksl_add_engine;

  localparam int NUM_CH = 9;

  typedef struct {
    int chan;
    int val;
    int cyc;
    bit bp;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int   nVec = 0;
  int   nErr = 0;
  int   cyc = 0;
  int   clrRem = 0;
  int   mcache [16];
  int   rdExp = 0;
  bit   rdExpValid = 0;
  bit   prevStall = 0;
  int   prevChan = 0;
  int   prevVal = 0;
  exp_t q [$];
  exp_t monEntry;
  int   kslTable [16] = '{0, 32, 40, 45, 48, 51, 53, 55, 56, 58, 59, 60, 61, 62, 63, 64};
  int   rd2Exp;

  ksl_add_engine_if #(.CHAN_WIDTH(4), .KSL_ADD_WIDTH(8)) bus ();

  ksl_add_engine #(.NUM_CHANNELS(NUM_CH), .CHAN_WIDTH(4), .KSL_ADD_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic int kslModel(input int f, input int b, input int k);
    int t;
    t = kslTable[f / 64] + 8 * (b - 8);
    if (t <= 0) return 0;
    case (k)
      1:       return t * 2;
      2:       return t;
      3:       return t * 4;
      default: return 0;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nVec++;
    assert (obs === expv) else begin
      nErr++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, expv);
    end
  endtask

  task automatic resetModel();
    q.delete();
    foreach (mcache[i]) mcache[i] = 0;
    clrRem     = 0;
    rdExpValid = 0;
    prevStall  = 0;
  endtask

  // Reference model and output checks, sampled on the falling edge
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      cyc++;
      if (prevStall) begin
        checkOutput("stall_valid", bus.out_valid, 1);
        checkOutput("stall_chan", bus.out_chan, prevChan);
        checkOutput("stall_value", bus.out_ksl_add, prevVal);
      end
      checkOutput("busy", bus.busy, clrRem > 0);
      if (clrRem > 0) checkOutput("in_ready_during_clear", bus.in_ready, 0);
      if (rdExpValid) checkOutput("rd_ksl_add", bus.rd_ksl_add, rdExp);
`ifdef KSL_ADD_CACHE_EN
      rdExpValid = (clrRem == 0);
      rdExp      = (bus.rd_chan < NUM_CH) ? mcache[bus.rd_chan] : 0;
`else
      rdExpValid = 1;
      rdExp      = 0;
`endif
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          checkOutput("out_without_request", q.size(), 1);
        end else begin
          monEntry = q.pop_front();
          checkOutput("out_chan", bus.out_chan, monEntry.chan);
          checkOutput("out_ksl_add", bus.out_ksl_add, monEntry.val);
          if (!monEntry.bp) checkOutput("latency", cyc - monEntry.cyc, 2);
`ifdef KSL_ADD_CACHE_EN
          if (monEntry.chan < NUM_CH && clrRem == 0) mcache[monEntry.chan] = monEntry.val;
`endif
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        monEntry.chan = int'(bus.in_chan);
        monEntry.val  = kslModel(int'(bus.fnum), int'(bus.block), int'(bus.ksl));
        monEntry.cyc  = cyc;
        monEntry.bp   = 0;
        q.push_back(monEntry);
      end
      if (!bus.out_ready) foreach (q[i]) q[i].bp = 1;
`ifdef KSL_ADD_CACHE_EN
      if (clrRem > 0) begin
        clrRem--;
      end else if (bus.clear) begin
        clrRem = NUM_CH;
        foreach (mcache[i]) mcache[i] = 0;
      end
`endif
      prevStall = bus.out_valid && !bus.out_ready;
      prevChan  = int'(bus.out_chan);
      prevVal   = int'(bus.out_ksl_add);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic randFields(input int maxChan);
    bus.in_chan = 4'($urandom_range(0, maxChan));
    bus.fnum    = 10'($urandom_range(0, 1023));
    bus.block   = 3'($urandom_range(0, 7));
    bus.ksl     = 2'($urandom_range(0, 3));
  endtask

  // Presents one request and returns just after the edge that accepted it
  task automatic applyStimulus(input int ch, input int f, input int b, input int k);
    bit acc;
    bit done;
    done         = 0;
    bus.in_valid = 1'b1;
    bus.in_chan  = 4'(ch);
    bus.fnum     = 10'(f);
    bus.block    = 3'(b);
    bus.ksl      = 2'(k);
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      done = acc;
    end
    bus.in_valid = 1'b0;
    if (!done) checkOutput("accept_timeout", 0, 1);
  endtask

  task automatic sendAndCheck(input int ch, input int f, input int b, input int k, input int expv);
    applyStimulus(ch, f, b, k);
    @(negedge clk);
    @(negedge clk);
    checkOutput("direct_valid", bus.out_valid, 1);
    checkOutput("direct_chan", bus.out_chan, ch);
    checkOutput("direct_value", bus.out_ksl_add, expv);
    @(posedge clk);
    #1;
  endtask

  task automatic readAll();
    for (int ch = 0; ch < 16; ch++) begin
      bus.rd_chan = 4'(ch);
      @(posedge clk);
      #1;
    end
    idle(1);
  endtask

  task automatic randomStream(input int n);
    repeat (n) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      randFields(15);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
  endtask

  initial begin
    int nacc;
    bit acc;
    resetModel();
    bus.in_valid  = 1'b0;
    bus.in_chan   = '0;
    bus.fnum      = '0;
    bus.block     = '0;
    bus.ksl       = '0;
    bus.out_ready = 1'b1;
    bus.clear     = 1'b0;
    bus.rd_chan   = '0;
`ifdef KSL_ADD_CACHE_EN
    rd2Exp = 224;
`else
    rd2Exp = 0;
`endif

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_out_valid", bus.out_valid, 0);
    checkOutput("reset_out_chan", bus.out_chan, 0);
    checkOutput("reset_out_ksl_add", bus.out_ksl_add, 0);
    checkOutput("reset_rd_ksl_add", bus.rd_ksl_add, 0);
    checkOutput("reset_busy", bus.busy, 0);
    rst = 1'b1;
    idle(2);
    checkOutput("idle_in_ready", bus.in_ready, 1);

    sendAndCheck(2, 'h3FF, 7, 3, 224);
    bus.rd_chan = 4'd2;
    idle(1);
    @(negedge clk);
    checkOutput("rd_chan2", bus.rd_ksl_add, rd2Exp);
    idle(2);
    sendAndCheck(0, 'h200, 6, 2, 40);
    idle(2);
    sendAndCheck(1, 'h200, 6, 1, 80);
    idle(2);
    sendAndCheck(3, 'h200, 6, 0, 0);
    idle(2);
    sendAndCheck(4, 'h040, 3, 3, 0);
    idle(2);

    for (int ch = 0; ch < NUM_CH; ch++)
      applyStimulus(ch, $urandom_range(0, 1023), $urandom_range(0, 7), $urandom_range(0, 3));
    idle(4);
    readAll();

    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    randFields(8);
    nacc = 0;
    repeat (5) begin
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        nacc++;
        randFields(8);
      end
    end
    checkOutput("bp_accepts", nacc, 2);
    checkOutput("bp_in_ready", bus.in_ready, 0);
    bus.out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk);
      #1;
      if (acc) randFields(8);
    end
    bus.in_valid = 1'b0;
    idle(4);

    for (int ch = 0; ch < NUM_CH; ch++)
      applyStimulus(ch, $urandom_range(512, 1023), $urandom_range(5, 7), $urandom_range(1, 3));
    idle(4);
    readAll();
    applyStimulus(5, 'h3FF, 7, 2);
    bus.clear = 1'b1;
    idle(1);
    bus.clear = 1'b0;
    idle(3);
    bus.clear = 1'b1;
    idle(1);
    bus.clear = 1'b0;
    applyStimulus(6, 'h200, 6, 2);
    idle(4);
    readAll();

    sendAndCheck(12, 'h3FF, 7, 2, 56);
    idle(2);
    readAll();

    randomStream(60);
    idle(4);
    readAll();

    bus.out_ready = 1'b1;
    repeat (3) begin
      bus.in_valid = 1'b1;
      randFields(8);
      @(posedge clk);
      #1;
    end
    #1;
    rst = 1'b0;
    resetModel();
    #1;
    checkOutput("midrst_out_valid", bus.out_valid, 0);
    checkOutput("midrst_out_ksl_add", bus.out_ksl_add, 0);
    checkOutput("midrst_busy", bus.busy, 0);
    checkOutput("midrst_rd_ksl_add", bus.rd_ksl_add, 0);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle(2);
    readAll();
    randomStream(30);

    for (int i = 0; i < 100 && q.size() != 0; i++) @(posedge clk);
    #1;
    checkOutput("drain", q.size(), 0);
    idle(2);
    $display("[TB] == %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
